// File: rtl/fetch_ctrl_pkg.sv
// ============================================================================
// fetch_ctrl_pkg : shared fetch/decode constants and FSM state encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_ctrl_pkg;

   localparam logic [31:0] NOP          = 32'h0000_0000;
   localparam logic [31:0] RESET_VEC    = 32'h0000_0000;
   localparam logic [31:0] INT_VEC_ADDR = 32'h0000_0001;

   typedef enum logic [1:0] {
      ST_BOOT    = 2'd0,
      ST_RUN     = 2'd1,
      ST_INT_VEC = 2'd2
   } fetch_state_e;

   // Sequential successor; wraps 32'hFFFFFFFF -> 0 by natural overflow.
   function automatic logic [31:0] pc_incr(input logic [31:0] pc);
      return pc + 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
// ============================================================================
// fetch_ctrl_if : redirect/hazard inputs, instruction memory and buffer bus
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_ctrl_if;

   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        int_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        buf_enable;
   logic [31:0] buf_pc;
   logic [31:0] buf_instruction;
   logic        buf_int;

   modport master (
      input  stall, branch_taken, branch_target, int_req, imem_data,
      output imem_addr, buf_enable, buf_pc, buf_instruction, buf_int
   );

   modport slave (
      output stall, branch_taken, branch_target, int_req, imem_data,
      input  imem_addr, buf_enable, buf_pc, buf_instruction, buf_int
   );

endinterface

`default_nettype wire

// File: rtl/fetch_ctrl_pc_reg.sv
// ============================================================================
// pc_reg : 32-bit program counter with synchronous active-low reset and load
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_reg #(
   parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        load,
   input  wire logic [31:0] d,
   output logic      [31:0] q
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q <= RST_VAL;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign q = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// fetch_ctrl : instruction fetch FSM with branch redirect, stall and interrupt
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_ctrl
   import fetch_ctrl_pkg::*;
(
   input  wire logic     clk,
   input  wire logic     rst,
   fetch_ctrl_if.master  bus
);

   fetch_state_e state_q;
   fetch_state_e state_d;
   logic         int_pending_q;
   logic         int_pending_d;
   logic [31:0]  pc_q;
   logic [31:0]  pc_d;
   logic         pc_load;

   logic [31:0]  imem_addr;
   logic         buf_enable;
   logic [31:0]  buf_pc;
   logic [31:0]  buf_instruction;
   logic         buf_int;

   pc_reg #(
      .RST_VAL (RESET_VEC)
   ) u_pc_reg (
      .clk  (clk),
      .rst  (rst),
      .load (pc_load),
      .d    (pc_d),
      .q    (pc_q)
   );

   always_comb begin
      state_d         = state_q;
      int_pending_d   = int_pending_q | bus.int_req;
      pc_d            = pc_q;
      pc_load         = 1'b0;
      imem_addr       = pc_q;
      buf_enable      = 1'b0;
      buf_pc          = pc_q;
      buf_instruction = bus.imem_data;
      buf_int         = 1'b0;

      // While reset is held the buffer sees the boot NOP, whatever the state.
      if (!rst) begin
         state_d         = ST_BOOT;
         int_pending_d   = 1'b0;
         imem_addr       = RESET_VEC;
         buf_enable      = 1'b1;
         buf_pc          = RESET_VEC;
         buf_instruction = NOP;
      end else begin
         case (state_q)
            ST_BOOT: begin
               imem_addr       = RESET_VEC;
               buf_enable      = 1'b1;
               buf_pc          = RESET_VEC;
               buf_instruction = NOP;
               pc_d            = bus.imem_data;
               pc_load         = 1'b1;
               state_d         = ST_RUN;
            end
            ST_RUN: begin
               if (bus.branch_taken) begin
                  buf_enable      = 1'b1;
                  buf_instruction = NOP;
                  pc_d            = bus.branch_target;
                  pc_load         = 1'b1;
               end else if (bus.stall) begin
                  buf_enable = 1'b0;
               end else if (int_pending_q || bus.int_req) begin
                  // pc is the return address and is held across the vector fetch.
                  buf_enable      = 1'b1;
                  buf_int         = 1'b1;
                  buf_instruction = NOP;
                  int_pending_d   = 1'b0;
                  state_d         = ST_INT_VEC;
               end else begin
                  buf_enable = 1'b1;
                  pc_d       = pc_incr(pc_q);
                  pc_load    = 1'b1;
               end
            end
            ST_INT_VEC: begin
               imem_addr       = INT_VEC_ADDR;
               buf_enable      = 1'b1;
               buf_instruction = NOP;
               pc_d            = bus.imem_data;
               pc_load         = 1'b1;
               state_d         = ST_RUN;
            end
            default: begin
               state_d = ST_BOOT;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_BOOT;
         int_pending_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         int_pending_q <= int_pending_d;
      end
   end

   assign bus.imem_addr       = imem_addr;
   assign bus.buf_enable      = buf_enable;
   assign bus.buf_pc          = buf_pc;
   assign bus.buf_instruction = buf_instruction;
   assign bus.buf_int         = buf_int;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// tb_fetch_ctrl : directed cycle-table bench for fetch_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   fetch_ctrl_if bus ();

   fetch_ctrl u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: word 0 = boot target, word 1 = interrupt vector.
   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (a == 32'd0) return 32'h0000_0010;
      if (a == 32'd1) return 32'h0000_0080;
      return {16'hC0DE, a[15:0]};
   endfunction

   assign bus.imem_data = mem_rd(bus.imem_addr);

   typedef struct {
      logic        rst;
      logic        stall;
      logic        br;
      logic [31:0] tgt;
      logic        irq;
      logic        en;
      logic [31:0] addr;
      logic [31:0] pc;
      logic        bint;
      logic        nop;
   } vec_t;

   localparam int NV = 28;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic r, input logic s, input logic b,
                               input logic [31:0] t, input logic q,
                               input logic en, input logic [31:0] addr,
                               input logic [31:0] pc, input logic bi,
                               input logic nop);
      vec_t v;
      v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.irq = q;
      v.en = en; v.addr = addr; v.pc = pc; v.bint = bi; v.nop = nop;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One cycle: drive inputs, compare combinational outputs mid-cycle, clock.
   task automatic cyc(input string nm, input vec_t v);
      logic [31:0] exp_ins;
      rst               = v.rst;
      bus.stall         = v.stall;
      bus.branch_taken  = v.br;
      bus.branch_target = v.tgt;
      bus.int_req       = v.irq;
      exp_ins = v.nop ? 32'h0 : mem_rd(v.addr);
      @(negedge clk);
      chk({nm, ".en"},   {31'd0, bus.buf_enable}, {31'd0, v.en});
      chk({nm, ".addr"}, bus.imem_addr, v.addr);
      chk({nm, ".pc"},   bus.buf_pc, v.pc);
      chk({nm, ".int"},  {31'd0, bus.buf_int}, {31'd0, v.bint});
      chk({nm, ".ins"},  bus.buf_instruction, exp_ins);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst               = 1'b0;
      bus.stall         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 32'h0;
      bus.int_req       = 1'b0;
      @(posedge clk);
      #1;

      //               rst  st   br   tgt          irq   en   addr          pc            int  nop
      tbl[0]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b0, 1'b1,32'h0,       32'h0,       1'b0,1'b1);
      tbl[1]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b0, 1'b1,32'h0,       32'h0,       1'b0,1'b1);
      tbl[2]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b0, 1'b1,32'h10,      32'h10,      1'b0,1'b0);
      tbl[3]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b0, 1'b1,32'h11,      32'h11,      1'b0,1'b0);
      tbl[4]  = mk(1'b1,1'b1,1'b0,32'h0,       1'b0, 1'b0,32'h12,      32'h12,      1'b0,1'b0);
      tbl[5]  = mk(1'b1,1'b1,1'b0,32'h0,       1'b0, 1'b0,32'h12,      32'h12,      1'b0,1'b0);
      tbl[6]  = mk(1'b1,1'b1,1'b0,32'h0,       1'b0, 1'b0,32'h12,      32'h12,      1'b0,1'b0);
      tbl[7]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b0, 1'b1,32'h12,      32'h12,      1'b0,1'b0);
      tbl[8]  = mk(1'b1,1'b1,1'b1,32'h40,      1'b0, 1'b1,32'h13,      32'h13,      1'b0,1'b1);
      tbl[9]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b0, 1'b1,32'h40,      32'h40,      1'b0,1'b0);
      tbl[10] = mk(1'b1,1'b0,1'b1,32'h20,      1'b0, 1'b1,32'h41,      32'h41,      1'b0,1'b1);
      tbl[11] = mk(1'b1,1'b0,1'b0,32'h0,       1'b1, 1'b1,32'h20,      32'h20,      1'b1,1'b1);
      tbl[12] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0, 1'b1,32'h1,       32'h20,      1'b0,1'b1);
      tbl[13] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0, 1'b1,32'h80,      32'h80,      1'b0,1'b0);
      tbl[14] = mk(1'b1,1'b0,1'b1,32'h50,      1'b1, 1'b1,32'h81,      32'h81,      1'b0,1'b1);
      tbl[15] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0, 1'b1,32'h50,      32'h50,      1'b1,1'b1);
      tbl[16] = mk(1'b1,1'b1,1'b1,32'h99,      1'b1, 1'b1,32'h1,       32'h50,      1'b0,1'b1);
      tbl[17] = mk(1'b1,1'b1,1'b0,32'h0,       1'b0, 1'b0,32'h80,      32'h80,      1'b0,1'b0);
      tbl[18] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0, 1'b1,32'h80,      32'h80,      1'b1,1'b1);
      tbl[19] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0, 1'b1,32'h1,       32'h80,      1'b0,1'b1);
      tbl[20] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0, 1'b1,32'h80,      32'h80,      1'b0,1'b0);
      tbl[21] = mk(1'b1,1'b1,1'b0,32'h0,       1'b1, 1'b0,32'h81,      32'h81,      1'b0,1'b0);
      tbl[22] = mk(1'b1,1'b0,1'b0,32'h0,       1'b1, 1'b1,32'h81,      32'h81,      1'b1,1'b1);
      tbl[23] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0, 1'b1,32'h1,       32'h81,      1'b0,1'b1);
      tbl[24] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0, 1'b1,32'h80,      32'h80,      1'b0,1'b0);
      tbl[25] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0, 1'b1,32'h0,       32'h0,       1'b0,1'b1);
      tbl[26] = mk(1'b1,1'b0,1'b1,32'h77,      1'b0, 1'b1,32'h0,       32'h0,       1'b0,1'b1);
      tbl[27] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0, 1'b1,32'h10,      32'h10,      1'b0,1'b0);

      for (int i = 0; i < NV; i++) begin
         cyc($sformatf("row%0d", i), tbl[i]);
      end

      // PC wrap through a branch to the top of the address space.
      cyc("wrap_br",  mk(1'b1,1'b0,1'b1,32'hFFFF_FFFF,1'b0, 1'b1,32'h11,       32'h11,       1'b0,1'b1));
      cyc("wrap_top", mk(1'b1,1'b0,1'b0,32'h0,        1'b0, 1'b1,32'hFFFF_FFFF,32'hFFFF_FFFF,1'b0,1'b0));
      cyc("wrap_0",   mk(1'b1,1'b0,1'b0,32'h0,        1'b0, 1'b1,32'h0,        32'h0,        1'b0,1'b0));

      // Reset while in INT_VEC must drop the interrupt and reboot.
      cyc("rv_inj",   mk(1'b1,1'b0,1'b0,32'h0,        1'b1, 1'b1,32'h1,        32'h1,        1'b1,1'b1));
      cyc("rv_rst",   mk(1'b0,1'b0,1'b0,32'h0,        1'b0, 1'b1,32'h0,        32'h0,        1'b0,1'b1));
      cyc("rv_boot",  mk(1'b1,1'b0,1'b0,32'h0,        1'b0, 1'b1,32'h0,        32'h0,        1'b0,1'b1));
      cyc("rv_run0",  mk(1'b1,1'b0,1'b0,32'h0,        1'b0, 1'b1,32'h10,       32'h10,       1'b0,1'b0));
      cyc("rv_run1",  mk(1'b1,1'b0,1'b0,32'h0,        1'b0, 1'b1,32'h11,       32'h11,       1'b0,1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
